flit_input_fifo: RTL

Per-port input buffer of the router. It stores incoming flits and presents the head flit first-word-fall-through. It exports `empty` and the head flit's one-hot type to the downstream read-initiation logic. The downstream read logic (init_rd plus the routing/arbiter read) drives `rd_en` to pop flits.

---
 rtl/flit_input_fifo.sv | 65 ++++++
 1 files changed

// File: rtl/flit_input_fifo.sv
// Per-port router input buffer: circular flit store with first-word-fall-through head,
// one-hot type export for read initiation, occupancy count and sticky error flags.
module flit_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [2:0]            flit_type,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A full buffer still takes a write when the head leaves in the same cycle.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full && !rd_en) overflow  <= 1'b1;
      if (rd_en && empty)          underflow <= 1'b1;
    end
  end

  // Flit storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  assign dout      = empty ? '0 : mem[rd_ptr];
  assign flit_type = dout[DATA_WIDTH-1 -: 3];

endmodule
